fifo_rd_stream: RTL and testbench
=================================

// Module: fifo_rd_stream
// PURPOSE
// - Read-side master for the fall-through-free FIFO: drives rd_en, captures rd_data after fixed read latency,
//   presents words on a valid/ready stream to downstream logic.
// - Sits between FIFO read port (empty, rd_en, rd_data) and any stream consumer; sustains 1 word/clk when
//   FIFO non-empty and out_ready held high.
// - Credit-based: never issues a read whose data it cannot buffer; never drops or duplicates a word.
// PARAMETERS
// - WIDTH    32  data word width (matches FIFO WIDTH)
// - RD_LAT   1   FIFO rd_en -> rd_data latency in clocks; legal 1..2 (elaboration $error otherwise)
// - BUF_DEP  RD_LAT+1  local output buffer depth (localparam, not overridable)
// PORTS
// - clk         in   1      single clock for all logic
// - rst         in   1      asynchronous, active-high reset
// - empty       in   1      FIFO empty flag (registered in FIFO, same clk)
// - rd_en       out  1      FIFO read strobe; one word popped per high cycle
// - rd_data     in   WIDTH  FIFO read data, valid RD_LAT clks after rd_en
// - out_valid   out  1      out_data holds a valid word
// - out_ready   in   1      consumer accepts word when out_valid && out_ready
// - out_data    out  WIDTH  head of local buffer
// - flush       in   1      discard buffered and in-flight words
// - words_out   out  32     count of words accepted downstream (wraps at 2^32)
// BEHAVIOUR
// - Reset (async assert, sync release): rd_en=0, out_valid=0, out_data=0, words_out=0, buffer empty,
//   in-flight pipe cleared.
// - In-flight pipe: RD_LAT-deep shift reg of valid bits; bit set when rd_en=1, write to buffer when it exits.
// - Credit: inflight = popcount(pipe); rd_en = !empty && !flush && (inflight + buf_cnt - pop) < BUF_DEP,
//   where pop = out_valid && out_ready (same-cycle pop frees a credit).
// - rd_en combinational from registered state + empty + out_ready + flush; no rd_en while empty=1.
// - Buffer: circular, BUF_DEP entries, wr/rd pointers wrap modulo BUF_DEP; simultaneous push+pop keeps
//   buf_cnt unchanged; push into empty buffer -> out_valid the following clk (no comb path rd_data->out).
// - Latency: rd_en at cycle N -> out_valid earliest at N+RD_LAT+1.
// - out_data stable while out_valid && !out_ready (stream hold rule); out_valid never drops without pop or flush.
// - Overflow impossible by construction; assertion: push && buf_cnt==BUF_DEP && !pop is a fatal error.
// - flush=1 (one clk): buffer emptied, pipe valid bits cleared (in-flight words still popped from FIFO
//   are discarded on arrival), out_valid=0 next clk, rd_en=0 that clk; words_out unchanged.
// - flush coinciding with pop: pop counts in words_out, word is not re-presented.
// - words_out increments by 1 per accepted word; 32'hFFFF_FFFF + 1 -> 0.
// - empty asserting mid-burst: rd_en drops same clk; in-flight words still delivered.
// - rst mid-burst: all state cleared immediately; in-flight FIFO data discarded.
// STRUCTURE
// - fifo_pkg: RD_LAT legal-range constants, clog2-derived pointer width helper, shared stream word typedef
//   (also used by the FIFO write-side block).
// - One sub-module: fifo_rd_skid_buf (BUF_DEP circular buffer: push, pop, flush, cnt, head data).
// - Top: credit logic, in-flight pipe, words_out counter, assertions.
// TESTING
// - Stream: FIFO preloaded 0x1..0x10, out_ready=1 -> 16 words in order, 1/clk after RD_LAT+1, words_out=16.
// - Backpressure: 8 words, out_ready=0 for 10 clks -> rd_en stops at BUF_DEP reads, out_data=0x1 held,
//   release -> 0x1..0x8 in order, no loss.
// - Empty toggle: write 1 word every 3 clks, out_ready=1 -> rd_en never high while empty=1, all words out.
// - Flush: 6 words buffered/in flight, flush pulse -> out_valid=0 next clk, next word out is 7th FIFO word.
// - Wrap: preload words_out near 32'hFFFF_FFFE via force, accept 3 words -> words_out=1.
// - Reset: assert rst with 2 words in flight -> rd_en/out_valid 0 asynchronously; post-release no stale word.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the FIFO read/write side blocks.
package fifo_pkg;

    localparam int RD_LAT_MIN   = 1;
    localparam int RD_LAT_MAX   = 2;
    localparam int STREAM_WIDTH = 32;

    typedef logic [STREAM_WIDTH-1:0] stream_word_t;

    // A one-entry or two-entry structure still needs a 1-bit pointer.
    function automatic int ptr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// FIFO read port plus downstream valid/ready stream, seen from the read-side master.
interface fifo_rd_stream_if #(
    parameter int WIDTH = 32
);
    logic             empty;
    logic             rd_en;
    logic [WIDTH-1:0] rd_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        input  empty, rd_data, out_ready,
        output rd_en, out_valid, out_data
    );

    modport slave (
        output empty, rd_data, out_ready,
        input  rd_en, out_valid, out_data
    );
endinterface

// File: rtl/fifo_rd_skid_buf.sv
// Small circular output buffer: push at tail, pop at head, flush empties it in one clock.
module fifo_rd_skid_buf
    import fifo_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 2,
    localparam int CW    = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [CW-1:0]    cnt,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data
);
    localparam int PW = ptr_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             pop_eff;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign pop_eff = pop && (cnt_q != '0);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        // Flush wins over a same-cycle push: a word arriving with flush is dropped.
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (pop_eff) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({push, pop_eff})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign cnt        = cnt_q;
    assign head_valid = (cnt_q != '0);
    assign head_data  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side master for a FIFO: credit-limited rd_en, fixed-latency capture, valid/ready output.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    fifo_rd_stream_if.master bus,
    input  logic             flush,
    output logic [31:0]      words_out
);
    localparam int BUF_DEP = RD_LAT + 1;
    localparam int CW      = cnt_width(BUF_DEP);
    localparam int SW      = CW + 1;

    generate
        if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
            $error("fifo_rd_stream: RD_LAT must be 1 or 2");
        end
    endgenerate

    logic [RD_LAT-1:0] pipe_q, pipe_d;
    logic              run_q, run_d;
    logic [31:0]       words_out_q, words_out_d;
    logic [CW-1:0]     buf_cnt;
    logic              buf_valid;
    logic [WIDTH-1:0]  buf_head;
    logic              pop;
    logic              push;
    logic              rd_en;
    logic [SW-1:0]     inflight;
    logic [SW-1:0]     used;

    assign pop  = buf_valid && bus.out_ready;
    assign push = pipe_q[RD_LAT-1];

    // A read is only issued if its word has a guaranteed slot when it lands;
    // run_q keeps rd_en low from the instant rst asserts until the first clock after release.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + SW'(pipe_q[i]);
        end
        used  = inflight + SW'(buf_cnt) - SW'(pop);
        rd_en = run_q && !bus.empty && !flush && (used < SW'(BUF_DEP));
    end

    always_comb begin
        pipe_d = '0;
        if (!flush) begin
            pipe_d[0] = rd_en;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_d[i] = pipe_q[i-1];
            end
        end
        run_d       = 1'b1;
        words_out_d = words_out_q + 32'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_q      <= '0;
            run_q       <= 1'b0;
            words_out_q <= '0;
        end else begin
            pipe_q      <= pipe_d;
            run_q       <= run_d;
            words_out_q <= words_out_d;
        end
    end

    fifo_rd_skid_buf #(
        .WIDTH (WIDTH),
        .DEPTH (BUF_DEP)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_data  (bus.rd_data),
        .pop        (pop),
        .flush      (flush),
        .cnt        (buf_cnt),
        .head_valid (buf_valid),
        .head_data  (buf_head)
    );

    assign bus.rd_en     = rd_en;
    assign bus.out_valid = buf_valid;
    assign bus.out_data  = buf_head;
    assign words_out     = words_out_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !flush && buf_cnt == CW'(BUF_DEP) && !pop))
        else $fatal(1, "fifo_rd_stream: local buffer overflow");

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: FIFO model, word-order scoreboard, directed scenarios.
module tb_fifo_rd_stream;
    import fifo_pkg::*;

    localparam int WIDTH   = 32;
    localparam int RD_LAT  = 1;
    localparam int BUF_DEP = RD_LAT + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        ready = 1'b0;
    logic [31:0] words_out;

    logic         fifo_empty = 1'b1;
    stream_word_t fifo_rdata = '0;
    stream_word_t fifo_q[$];

    fifo_rd_stream_if #(.WIDTH(WIDTH)) bus();

    assign bus.empty     = fifo_empty;
    assign bus.rd_data   = fifo_rdata;
    assign bus.out_ready = ready;

    fifo_rd_stream #(
        .WIDTH  (WIDTH),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .flush     (flush),
        .words_out (words_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // FIFO with one-clock read latency and a registered empty flag.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.rd_en && fifo_q.size() > 0) fifo_rdata <= fifo_q.pop_front();
        else                                fifo_rdata <= 32'hDEAD_BEEF;
        fifo_empty <= (fifo_q.size() == 0);
    end

    // Scoreboard: words popped from the FIFO and not yet accepted or discarded.
    stream_word_t exp_q[$];
    stream_word_t seen_q[$];
    logic [31:0]  acc_m = '0;
    logic         hold_prev = 1'b0;
    stream_word_t prev_data = '0;
    int           reads_issued = 0;
    int           first_rd = -1, first_valid = -1, first_acc = -1, last_acc = -1;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_rd_en", 32'(bus.rd_en), 0);
            chk("rst_out_valid", 32'(bus.out_valid), 0);
            chk("rst_words_out", words_out, 0);
            exp_q.delete();
            acc_m     = '0;
            hold_prev = 1'b0;
        end else begin
            if (bus.rd_en) chk("rd_en_while_empty", 32'(fifo_empty), 0);
            if (flush)     chk("flush_rd_en", 32'(bus.rd_en), 0);
            if (hold_prev) begin
                chk("hold_valid", 32'(bus.out_valid), 1);
                chk("hold_data", bus.out_data, prev_data);
            end
            chk("words_out", words_out, acc_m);
            if (bus.out_valid) begin
                if (first_valid < 0) first_valid = cyc;
                chk("spurious_word", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) chk("out_data", bus.out_data, exp_q[0]);
                if (ready) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    seen_q.push_back(bus.out_data);
                    $display("accept #%0d data=%h cycle=%0d", acc_m + 1, bus.out_data, cyc);
                    acc_m = acc_m + 1;
                    if (first_acc < 0) first_acc = cyc;
                    last_acc = cyc;
                end
            end
            if (flush) exp_q.delete();
            if (bus.rd_en && fifo_q.size() > 0) begin
                exp_q.push_back(fifo_q[0]);
                reads_issued++;
                if (first_rd < 0) first_rd = cyc;
            end
            chk("credit_limit", 32'(exp_q.size() <= BUF_DEP), 1);
            hold_prev = bus.out_valid && !ready && !flush;
            prev_data = bus.out_data;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while ((exp_q.size() > 0 || fifo_q.size() > 0 || bus.out_valid) && k < budget) begin
            tick(1);
            k++;
        end
        chk("drain_timeout", 32'(k < budget), 1);
        tick(1);
    endtask

    task automatic clear_trace();
        seen_q.delete();
        first_rd = -1; first_valid = -1; first_acc = -1; last_acc = -1;
        reads_issued = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        tick(3);
        chk("reset_out_data", bus.out_data, 0);
        chk("reset_out_valid", 32'(bus.out_valid), 0);
        chk("reset_words_out", words_out, 0);
        rst = 1'b0;
        tick(2);

        // Streaming: 16 words at full rate
        clear_trace();
        for (int i = 1; i <= 16; i++) fifo_q.push_back(32'(i));
        ready = 1'b1;
        wait_drain(200);
        chk("stream_count", 32'(seen_q.size()), 16);
        for (int i = 0; i < 16 && i < seen_q.size(); i++) chk("stream_order", seen_q[i], 32'(i + 1));
        chk("stream_latency", 32'(first_valid - first_rd), 32'(RD_LAT + 1));
        chk("stream_rate", 32'(last_acc - first_acc), 15);
        chk("stream_words_out", words_out, 16);

        // Backpressure: reads stop once the buffer is committed
        ready = 1'b0;
        clear_trace();
        for (int i = 1; i <= 8; i++) fifo_q.push_back(32'(i));
        tick(10);
        chk("bp_reads", 32'(reads_issued), 2);
        chk("bp_valid", 32'(bus.out_valid), 1);
        chk("bp_head", bus.out_data, 32'h1);
        ready = 1'b1;
        clear_trace();
        wait_drain(200);
        chk("bp_count", 32'(seen_q.size()), 8);
        for (int i = 0; i < 8 && i < seen_q.size(); i++) chk("bp_order", seen_q[i], 32'(i + 1));

        // FIFO trickle: one word every 3 clocks
        clear_trace();
        for (int k = 0; k < 6; k++) begin
            fifo_q.push_back(32'h100 + 32'(k));
            tick(3);
        end
        wait_drain(200);
        chk("trickle_count", 32'(seen_q.size()), 6);
        for (int i = 0; i < 6 && i < seen_q.size(); i++) chk("trickle_order", seen_q[i], 32'h100 + 32'(i));
        chk("trickle_words_out", words_out, 30);

        // Flush: words 5 and 6 held, flushed; next word out must be 7
        for (int i = 1; i <= 4; i++) fifo_q.push_back(32'(i));
        wait_drain(200);
        ready = 1'b0;
        for (int i = 5; i <= 10; i++) fifo_q.push_back(32'(i));
        tick(6);
        chk("pre_flush_head", bus.out_data, 32'h5);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        chk("post_flush_valid", 32'(bus.out_valid), 0);
        ready = 1'b1;
        clear_trace();
        wait_drain(200);
        chk("flush_next_word", (seen_q.size() > 0) ? seen_q[0] : 32'hFFFF_FFFF, 32'h7);
        chk("flush_count", 32'(seen_q.size()), 4);
        chk("flush_words_out", words_out, 38);

        // Flush together with a pop: popped word counts and is not shown again
        ready = 1'b0;
        fifo_q.push_back(32'h11);
        fifo_q.push_back(32'h12);
        tick(4);
        flush = 1'b1;
        ready = 1'b1;
        tick(1);
        flush = 1'b0;
        ready = 1'b0;
        fifo_q.push_back(32'h13);
        tick(1);
        ready = 1'b1;
        clear_trace();
        wait_drain(200);
        chk("flush_pop_next", (seen_q.size() > 0) ? seen_q[0] : 32'hFFFF_FFFF, 32'h13);
        chk("flush_pop_words_out", words_out, 40);

        // Counter wrap
        ready = 1'b0;
        tick(2);
        force dut.words_out_q = 32'hFFFF_FFFE;
        acc_m = 32'hFFFF_FFFE;
        tick(1);
        release dut.words_out_q;
        for (int i = 0; i < 3; i++) fifo_q.push_back(32'h51 + 32'(i));
        ready = 1'b1;
        wait_drain(200);
        chk("wrap_words_out", words_out, 32'h1);

        // Reset with reads outstanding: those words are lost
        ready = 1'b0;
        for (int i = 0; i < 4; i++) fifo_q.push_back(32'h21 + 32'(i));
        tick(3);
        chk("pre_rst_valid", 32'(bus.out_valid), 1);
        rst = 1'b1;
        #1;
        chk("async_rst_rd_en", 32'(bus.rd_en), 0);
        chk("async_rst_valid", 32'(bus.out_valid), 0);
        chk("async_rst_words_out", words_out, 0);
        tick(2);
        rst = 1'b0;
        ready = 1'b1;
        clear_trace();
        wait_drain(200);
        chk("rst_next_word", (seen_q.size() > 0) ? seen_q[0] : 32'hFFFF_FFFF, 32'h23);
        chk("rst_count", 32'(seen_q.size()), 2);
        chk("rst_words_out_final", words_out, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
